// File: rtl/pl_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// pl_ctrl_pipe -- in-order control-word pipeline with stall and flush.
//
// Each stage holds one control word and its valid flag. On each rising edge
// words move one stage older. A stall holds stage 0 and puts a bubble into
// stage 1. A flush turns the youngest FLUSH_DEPTH stages into bubbles. A
// bubble is valid=0 with all-zero data, so downstream enables such as regwen
// and dmemrw are deasserted.
//
// Parameters
//   WIDTH       control-word width per stage
//   DEPTH       number of stages (2..8)
//   FLUSH_DEPTH number of youngest stages killed by flush (1..DEPTH)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (overrides stall and flush)
//   in_data    control word from decode
//   in_valid   in_data is a real instruction
//   stall      hold stage 0, bubble into stage 1
//   flush      discard younger work
//   out_data   stage k at [k*WIDTH +: WIDTH]
//   out_valid  bit k = valid of stage k
//   stall_cnt  saturating count of stall-only edges
//   flush_cnt  saturating count of flush edges
//
// Build option
//   PL_CTRL_PERF_EN  when defined, stall_cnt/flush_cnt are real counters;
//                    otherwise both read constant 0 and have no flops.
// ---------------------------------------------------------------------------

// One pipeline stage. Priority: reset, kill (bubble), hold, load.
module pl_ctrl_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_valid,
    input  logic             hold,
    input  logic             kill,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            // An invalid source always lands as zero data.
            data  <= src_valid ? src_data : '0;
            valid <= src_valid;
        end
    end
endmodule

module pl_ctrl_pipe #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    output logic [DEPTH*WIDTH-1:0] out_data,
    output logic [DEPTH-1:0]       out_valid,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            flush_cnt
);
    logic [DEPTH-1:0][WIDTH-1:0] data_pipe;
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] src_data;
    logic [DEPTH-1:0]            src_valid;
    logic [DEPTH-1:0]            hold;
    logic [DEPTH-1:0]            kill;

    // Flush dominates stall: with both asserted only the flush pattern applies.
    logic stall_only;
    assign stall_only = stall & ~flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        localparam bit IN_FLUSH = (k < FLUSH_DEPTH);
        localparam bit IS_ONE   = (k == 1);

        if (k == 0) begin : g_head
            assign src_data[k]  = in_data;
            assign src_valid[k] = in_valid;
            assign hold[k]      = stall_only;
        end else begin : g_body
            assign src_data[k]  = data_pipe[k-1];
            assign src_valid[k] = vld_pipe[k-1];
            assign hold[k]      = 1'b0;
        end

        // Stage 1 takes the bubble left behind a held stage 0.
        assign kill[k] = (flush & IN_FLUSH) | (stall_only & IS_ONE);

        pl_ctrl_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .src_data  (src_data[k]),
            .src_valid (src_valid[k]),
            .hold      (hold[k]),
            .kill      (kill[k]),
            .data      (data_pipe[k]),
            .valid     (vld_pipe[k])
        );
    end

    assign out_data  = data_pipe;
    assign out_valid = vld_pipe;

`ifdef PL_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_only && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pl_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_pl_ctrl_pipe -- directed scoreboard bench for pl_ctrl_pipe
// (WIDTH=4, DEPTH=3, FLUSH_DEPTH=2). Each driven cycle pushes the
// hand-computed state expected after the coming edge; a monitor pops and
// compares one entry just after every rising edge. Counter expectations
// collapse to 0 when PL_CTRL_PERF_EN is undefined.
// ---------------------------------------------------------------------------
module tb_pl_ctrl_pipe;
    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int FLUSH_DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [WIDTH-1:0]       in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   stall = 1'b0;
    logic                   flush = 1'b0;
    logic [DEPTH*WIDTH-1:0] out_data;
    logic [DEPTH-1:0]       out_valid;
    logic [31:0]            stall_cnt;
    logic [31:0]            flush_cnt;

    pl_ctrl_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic [2:0]  v;
        logic [31:0] sc;
        logic [31:0] fc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Drive one cycle and record the state expected after its rising edge.
    task automatic step(input logic r, input logic iv, input logic [3:0] id,
                        input logic st, input logic fl,
                        input logic [11:0] ed, input logic [2:0] ev,
                        input logic [31:0] esc, input logic [31:0] efc,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = iv; in_data = id; stall = st; flush = fl;
        e.d = ed; e.v = ev; e.name = name;
`ifdef PL_CTRL_PERF_EN
        e.sc = esc; e.fc = efc;
`else
        e.sc = 32'd0; e.fc = 32'd0;
`endif
        sb.push_back(e);
    endtask

    // Monitor: compares after every rising edge that has an expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (out_data !== e.d || out_valid !== e.v ||
                stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                n_bad++;
                $display("FAIL %s: got data=%h valid=%b sc=%h fc=%h, expected data=%h valid=%b sc=%h fc=%h",
                         e.name, out_data, out_valid, stall_cnt, flush_cnt,
                         e.d, e.v, e.sc, e.fc);
            end
        end
    end

    initial begin
        // Reset
        step(1, 0, 4'h0, 0, 0, 12'h000, 3'b000, 0, 0, "reset");
        step(1, 1, 4'hD, 1, 1, 12'h000, 3'b000, 0, 0, "reset_overrides");
        // Shift scenario
        step(0, 1, 4'hA, 0, 0, 12'h00A, 3'b001, 0, 0, "shift1");
        step(0, 1, 4'h5, 0, 0, 12'h0A5, 3'b011, 0, 0, "shift2");
        step(0, 1, 4'h3, 0, 0, 12'hA53, 3'b111, 0, 0, "shift3");
        step(0, 0, 4'hC, 0, 0, 12'h530, 3'b110, 0, 0, "invalid_is_zero");
        // Stall scenario: stage 0 = 7, stall two cycles with in_data = F
        step(0, 1, 4'h7, 0, 0, 12'h307, 3'b101, 0, 0, "load7");
        step(0, 1, 4'hF, 1, 0, 12'h007, 3'b001, 1, 0, "stall1");
        step(0, 1, 4'hF, 1, 0, 12'h007, 3'b001, 2, 0, "stall2");
        // Release and fill to {1,2,3}
        step(0, 1, 4'h1, 0, 0, 12'h071, 3'b011, 2, 0, "unstall");
        step(0, 1, 4'h2, 0, 0, 12'h712, 3'b111, 2, 0, "fill2");
        step(0, 1, 4'h3, 0, 0, 12'h123, 3'b111, 2, 0, "fill3");
        // Flush together with stall: flush wins, stall_cnt unchanged
        step(0, 1, 4'hE, 1, 1, 12'h200, 3'b100, 2, 1, "flush_stall");
        step(0, 1, 4'h4, 0, 0, 12'h004, 3'b001, 2, 1, "after_flush");
        step(0, 1, 4'h5, 0, 0, 12'h045, 3'b011, 2, 1, "fill5");
        step(0, 1, 4'h6, 0, 0, 12'h456, 3'b111, 2, 1, "fill6");
        step(0, 1, 4'h8, 1, 0, 12'h506, 3'b101, 3, 1, "stall_full");
        // Reset during the stall
        step(1, 1, 4'h8, 1, 0, 12'h000, 3'b000, 0, 0, "reset_mid_stall");
        step(0, 1, 4'h9, 0, 0, 12'h009, 3'b001, 0, 0, "after_reset");
        step(0, 1, 4'hA, 0, 0, 12'h09A, 3'b011, 0, 0, "fillA");
        step(0, 1, 4'hB, 0, 1, 12'h900, 3'b100, 0, 1, "flush_only");
        step(1, 1, 4'hB, 0, 1, 12'h000, 3'b000, 0, 0, "reset_mid_flush");
`ifdef PL_CTRL_PERF_EN
        // Saturation: preload stall counter then stall three times
        @(negedge clk);
        rst = 0; in_valid = 0; stall = 0; flush = 0;
        sb.push_back('{d: 12'h000, v: 3'b000, sc: 32'd0, fc: 32'd0, name: "idle"});
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        step(0, 0, 4'h0, 1, 0, 12'h000, 3'b000, 32'hFFFF_FFFF, 0, "sat1");
        step(0, 0, 4'h0, 1, 0, 12'h000, 3'b000, 32'hFFFF_FFFF, 0, "sat2");
        step(0, 0, 4'h0, 1, 0, 12'h000, 3'b000, 32'hFFFF_FFFF, 0, "sat3");
`endif
        @(negedge clk);
        rst = 0; stall = 0; flush = 0; in_valid = 0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
